// File: rtl/pipe_id_exe_reg.sv
// rtl/pipe_id_exe_reg.sv - ID/EXE pipeline register with load-use bubble insertion
// Hold freezes EXE; flush or a load-use hazard loads an all-zero bubble, counted saturating.
module pipe_id_exe_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [31:0]      ID_a,
  input  logic [31:0]      ID_b,
  input  logic [31:0]      ID_imm,
  input  logic [31:0]      ID_pc_plus_4,
  input  logic [4:0]       ID_reg_w_num,
  input  logic [3:0]       ID_aluc,
  input  logic             ID_alu_imm,
  input  logic             ID_shift,
  input  logic             ID_jal,
  input  logic             ID_wreg,
  input  logic             ID_m2reg,
  input  logic             ID_wmem,
  input  logic             ID_valid,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             hold,
  input  logic             flush,
  output logic [31:0]      EXE_a,
  output logic [31:0]      EXE_b,
  output logic [31:0]      EXE_imm,
  output logic [31:0]      EXE_pc_plus_4,
  output logic [4:0]       EXE_reg_w_num,
  output logic [3:0]       EXE_aluc,
  output logic             EXE_alu_imm,
  output logic             EXE_shift,
  output logic             EXE_jal,
  output logic             EXE_wreg,
  output logic             EXE_m2reg,
  output logic             EXE_wmem,
  output logic             EXE_valid,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_count
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc_plus_4;
    logic [4:0]  reg_w_num;
    logic [3:0]  aluc;
    logic        alu_imm;
    logic        shift;
    logic        jal;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        valid;
  } exe_t;

  exe_t             exe_q, exe_d, id_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_rs, hit_rt, bubble;

  assign id_s = '{a: ID_a, b: ID_b, imm: ID_imm, pc_plus_4: ID_pc_plus_4,
                  reg_w_num: ID_reg_w_num, aluc: ID_aluc, alu_imm: ID_alu_imm,
                  shift: ID_shift, jal: ID_jal, wreg: ID_wreg, m2reg: ID_m2reg,
                  wmem: ID_wmem, valid: ID_valid};

  // Only a valid load writing a non-zero register can stall; ALU results are forwarded.
  assign hit_rs = ID_use_rs & (ID_rs == exe_q.reg_w_num);
  assign hit_rt = ID_use_rt & (ID_rt == exe_q.reg_w_num);
  assign load_use_stall = exe_q.valid & exe_q.m2reg & exe_q.wreg &
                          (exe_q.reg_w_num != 5'd0) & ID_valid & (hit_rs | hit_rt);

  assign bubble = flush | (~hold & load_use_stall);

  always_comb begin
    exe_d = exe_q;
    cnt_d = cnt_q;
    if (bubble) begin
      exe_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else if (!hold) begin
      exe_d = id_s;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      exe_q <= '0;
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      cnt_q <= cnt_d;
    end
  end

  assign EXE_a         = exe_q.a;
  assign EXE_b         = exe_q.b;
  assign EXE_imm       = exe_q.imm;
  assign EXE_pc_plus_4 = exe_q.pc_plus_4;
  assign EXE_reg_w_num = exe_q.reg_w_num;
  assign EXE_aluc      = exe_q.aluc;
  assign EXE_alu_imm   = exe_q.alu_imm;
  assign EXE_shift     = exe_q.shift;
  assign EXE_jal       = exe_q.jal;
  assign EXE_wreg      = exe_q.wreg;
  assign EXE_m2reg     = exe_q.m2reg;
  assign EXE_wmem      = exe_q.wmem;
  assign EXE_valid     = exe_q.valid;
  assign bubble_count  = cnt_q;

endmodule

// File: tb/tb_pipe_id_exe_reg.sv
// tb/tb_pipe_id_exe_reg.sv - directed self-checking bench for pipe_id_exe_reg
module tb_pipe_id_exe_reg;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] ID_a, ID_b, ID_imm, ID_pc_plus_4;
  logic [4:0]  ID_reg_w_num, ID_rs, ID_rt;
  logic [3:0]  ID_aluc;
  logic        ID_alu_imm, ID_shift, ID_jal, ID_wreg, ID_m2reg, ID_wmem, ID_valid;
  logic        ID_use_rs, ID_use_rt, hold, flush;
  logic [31:0] EXE_a, EXE_b, EXE_imm, EXE_pc_plus_4;
  logic [4:0]  EXE_reg_w_num;
  logic [3:0]  EXE_aluc;
  logic        EXE_alu_imm, EXE_shift, EXE_jal, EXE_wreg, EXE_m2reg, EXE_wmem, EXE_valid;
  logic        load_use_stall;
  logic [15:0] bubble_count;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_id_exe_reg #(.CNT_W(16)) dut (
    .clock(clock), .resetn(resetn),
    .ID_a(ID_a), .ID_b(ID_b), .ID_imm(ID_imm), .ID_pc_plus_4(ID_pc_plus_4),
    .ID_reg_w_num(ID_reg_w_num), .ID_aluc(ID_aluc), .ID_alu_imm(ID_alu_imm),
    .ID_shift(ID_shift), .ID_jal(ID_jal), .ID_wreg(ID_wreg), .ID_m2reg(ID_m2reg),
    .ID_wmem(ID_wmem), .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .hold(hold), .flush(flush),
    .EXE_a(EXE_a), .EXE_b(EXE_b), .EXE_imm(EXE_imm), .EXE_pc_plus_4(EXE_pc_plus_4),
    .EXE_reg_w_num(EXE_reg_w_num), .EXE_aluc(EXE_aluc), .EXE_alu_imm(EXE_alu_imm),
    .EXE_shift(EXE_shift), .EXE_jal(EXE_jal), .EXE_wreg(EXE_wreg),
    .EXE_m2reg(EXE_m2reg), .EXE_wmem(EXE_wmem), .EXE_valid(EXE_valid),
    .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [4:0] rw, input logic m2reg,
                       input logic wreg, input logic valid, input logic [4:0] rs,
                       input logic [4:0] rt, input logic use_rs, input logic use_rt);
    ID_a = a; ID_b = a ^ 32'hFFFF_0000; ID_imm = a + 32'd4; ID_pc_plus_4 = a + 32'd8;
    ID_reg_w_num = rw; ID_aluc = 4'h3; ID_alu_imm = 1'b1; ID_shift = 1'b0; ID_jal = 1'b1;
    ID_wreg = wreg; ID_m2reg = m2reg; ID_wmem = 1'b0; ID_valid = valid;
    ID_rs = rs; ID_rt = rt; ID_use_rs = use_rs; ID_use_rt = use_rt;
    #1;
  endtask

  initial begin
    resetn = 1'b0; hold = 1'b0; flush = 1'b0;
    ID_a = '0; ID_b = '0; ID_imm = '0; ID_pc_plus_4 = '0; ID_reg_w_num = '0; ID_aluc = '0;
    ID_alu_imm = 0; ID_shift = 0; ID_jal = 0; ID_wreg = 0; ID_m2reg = 0; ID_wmem = 0;
    ID_valid = 0; ID_rs = '0; ID_rt = '0; ID_use_rs = 0; ID_use_rt = 0;
    #3;
    chk("reset_valid", {31'd0, EXE_valid}, 32'd0);
    chk("reset_a", EXE_a, 32'd0);
    chk("reset_cnt", {16'd0, bubble_count}, 32'd0);
    step(); step();
    resetn = 1'b1;

    // normal load
    ID_a = 32'h1234; ID_aluc = 4'h2; ID_wreg = 1'b1; ID_valid = 1'b1;
    step();
    chk("norm_a", EXE_a, 32'h1234);
    chk("norm_aluc", {28'd0, EXE_aluc}, 32'd2);
    chk("norm_wreg", {31'd0, EXE_wreg}, 32'd1);
    chk("norm_valid", {31'd0, EXE_valid}, 32'd1);
    chk("norm_cnt", {16'd0, bubble_count}, 32'd0);

    // load-use on rt
    drive(32'h100, 5'd5, 1, 1, 1, 5'd0, 5'd0, 0, 0);
    step();
    chk("lw_in_exe", {27'd0, EXE_reg_w_num}, 32'd5);
    drive(32'hAAAA, 5'd7, 0, 1, 1, 5'd1, 5'd5, 0, 1);
    chk("rt_stall", {31'd0, load_use_stall}, 32'd1);
    step();
    chk("bub_valid", {31'd0, EXE_valid}, 32'd0);
    chk("bub_wreg", {31'd0, EXE_wreg}, 32'd0);
    chk("bub_a", EXE_a, 32'd0);
    chk("bub_jal", {31'd0, EXE_jal}, 32'd0);
    chk("bub_cnt", {16'd0, bubble_count}, 32'd1);
    chk("bub_stall_clr", {31'd0, load_use_stall}, 32'd0);
    step();
    chk("after_a", EXE_a, 32'hAAAA);
    chk("after_rw", {27'd0, EXE_reg_w_num}, 32'd7);
    chk("after_b", EXE_b, 32'hFFFF_AAAA);
    chk("after_jal", {31'd0, EXE_jal}, 32'd1);
    chk("after_cnt", {16'd0, bubble_count}, 32'd1);

    // no false stall: r0 load, unused rt, non-load writer
    drive(32'h200, 5'd0, 1, 1, 1, 5'd0, 5'd0, 0, 0);
    step();
    drive(32'h201, 5'd2, 0, 1, 1, 5'd0, 5'd0, 1, 1);
    chk("r0_nostall", {31'd0, load_use_stall}, 32'd0);
    drive(32'h300, 5'd5, 1, 1, 1, 5'd0, 5'd0, 0, 0);
    step();
    drive(32'h301, 5'd2, 0, 1, 1, 5'd5, 5'd5, 0, 0);
    chk("unused_nostall", {31'd0, load_use_stall}, 32'd0);
    drive(32'h400, 5'd5, 0, 1, 1, 5'd0, 5'd0, 0, 0);
    step();
    drive(32'h401, 5'd2, 0, 1, 1, 5'd0, 5'd5, 0, 1);
    chk("alu_nostall", {31'd0, load_use_stall}, 32'd0);
    step();
    chk("nostall_a", EXE_a, 32'h401);
    chk("nostall_cnt", {16'd0, bubble_count}, 32'd1);

    // load-use on rs
    drive(32'h500, 5'd9, 1, 1, 1, 5'd0, 5'd0, 0, 0);
    step();
    drive(32'h501, 5'd2, 0, 1, 1, 5'd9, 5'd0, 1, 0);
    chk("rs_stall", {31'd0, load_use_stall}, 32'd1);
    step();
    chk("rs_cnt", {16'd0, bubble_count}, 32'd2);

    // hold with a pending hazard: EXE frozen, counter unchanged
    drive(32'h600, 5'd5, 1, 1, 1, 5'd0, 5'd0, 0, 0);
    step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h700 + i, 5'd3, 0, 1, 1, 5'd0, 5'd5, 0, 1);
      step();
    end
    chk("hold_a", EXE_a, 32'h600);
    chk("hold_valid", {31'd0, EXE_valid}, 32'd1);
    chk("hold_stall", {31'd0, load_use_stall}, 32'd1);
    chk("hold_cnt", {16'd0, bubble_count}, 32'd2);
    flush = 1'b1;
    step();
    chk("hf_valid", {31'd0, EXE_valid}, 32'd0);
    chk("hf_cnt", {16'd0, bubble_count}, 32'd3);
    hold = 1'b0; flush = 1'b0;

    // flush coinciding with a load-use hazard counts once
    drive(32'h800, 5'd5, 1, 1, 1, 5'd0, 5'd0, 0, 0);
    step();
    drive(32'h801, 5'd2, 0, 1, 1, 5'd5, 5'd0, 1, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fs_cnt", {16'd0, bubble_count}, 32'd4);
    chk("fs_valid", {31'd0, EXE_valid}, 32'd0);

    // saturation
    resetn = 1'b0; #1; resetn = 1'b1;
    chk("pre_sat_cnt", {16'd0, bubble_count}, 32'd0);
    flush = 1'b1;
    repeat (65535) step();
    chk("sat_ffff", {16'd0, bubble_count}, 32'h0000_FFFF);
    step();
    chk("sat_hold", {16'd0, bubble_count}, 32'h0000_FFFF);
    flush = 1'b0;

    // asynchronous reset while stalling
    drive(32'h900, 5'd5, 1, 1, 1, 5'd0, 5'd0, 0, 0);
    step();
    drive(32'h901, 5'd2, 0, 1, 1, 5'd0, 5'd5, 0, 1);
    chk("ar_pre_stall", {31'd0, load_use_stall}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("ar_valid", {31'd0, EXE_valid}, 32'd0);
    chk("ar_a", EXE_a, 32'd0);
    chk("ar_rw", {27'd0, EXE_reg_w_num}, 32'd0);
    chk("ar_cnt", {16'd0, bubble_count}, 32'd0);
    chk("ar_stall", {31'd0, load_use_stall}, 32'd0);
    resetn = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_id_exe_reg.md
Name: pipe_id_exe_reg

Overview:
- ID/EXE pipeline register: the producer side of the execute-stage input interface.
- Captures the decoded operands and control fields from the decode stage each cycle and drives them to the execute stage.
- Detects load-use hazards against the instruction currently in EXE and inserts one bubble per hazard.
- Supports external hold (memory wait) and flush (branch/jump redirect), and counts inserted bubbles for performance monitoring.

Parameters:
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- ID_a, ID_b  in  32 each  register operands from decode
- ID_imm  in  32  extended immediate
- ID_pc_plus_4  in  32  PC+4 of the decoded instruction
- ID_reg_w_num  in  5  destination register number
- ID_aluc  in  4  ALU control code
- ID_alu_imm, ID_shift, ID_jal  in  1 each  operand/result select controls
- ID_wreg, ID_m2reg, ID_wmem  in  1 each  register-write, load, store controls
- ID_valid  in  1  decode slot holds a real instruction
- ID_rs, ID_rt  in  5 each  source register numbers
- ID_use_rs, ID_use_rt  in  1 each  instruction reads rs/rt
- hold  in  1  freeze the EXE register
- flush  in  1  kill the instruction entering EXE
- EXE_a, EXE_b, EXE_imm, EXE_pc_plus_4  out  32 each  registered operands
- EXE_reg_w_num  out  5  registered destination
- EXE_aluc  out  4  registered ALU control
- EXE_alu_imm, EXE_shift, EXE_jal, EXE_wreg, EXE_m2reg, EXE_wmem, EXE_valid  out  1 each  registered controls
- load_use_stall  out  1  combinational; the decode stage and PC must hold this cycle
- bubble_count  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (resetn=0, asynchronous): all EXE_* outputs are 0 and bubble_count is 0. Reset takes effect immediately, regardless of clock, including mid-stall or mid-hold.
- Hazard term, combinational: load_use_stall = EXE_valid & EXE_m2reg & EXE_wreg & (EXE_reg_w_num != 0) & ID_valid & ((ID_use_rs & ID_rs == EXE_reg_w_num) | (ID_use_rt & ID_rt == EXE_reg_w_num)).
- Register is 0 in ID-stage fields during bubble; the hazard term depends only on registered EXE state and ID inputs.
- Per rising edge, priority order:
  1. flush=1: bubble loaded.
  2. else hold=1: all EXE_* hold their values.
  3. else load_use_stall=1: bubble loaded.
  4. else: all ID_* fields are copied to EXE_*, and EXE_valid = ID_valid.
- Bubble definition:
  - EXE_valid, EXE_wreg, EXE_m2reg, EXE_wmem, EXE_jal, EXE_alu_imm, EXE_shift = 0.
  - EXE_aluc = 0 and EXE_reg_w_num = 0.
  - All 32-bit fields = 0.
- Load-use stall lasts exactly one cycle: the bubble clears EXE_valid, so load_use_stall deasserts on the next cycle and the held ID instruction then loads normally.
- Under hold, load_use_stall may remain asserted. No bubble is inserted and the counter is unchanged until hold drops.
- flush together with hold: flush wins and the bubble is counted.
- flush together with load_use_stall: a single bubble, counted once.
- bubble_count increments by 1 on each edge where a bubble is loaded (cases 1 and 3). It saturates at all-ones and never wraps. It does not change under hold.
- Loads into r0 (EXE_reg_w_num=0) never stall.
- Non-load writers (EXE_m2reg=0) never stall; the forwarding network covers them.
- The ID_jal path is passed through unchanged. Destination override to r31 is done downstream in EXE, not here.

Test Plan:
- Reset, then a normal load: release resetn; drive ID_a=32'h1234, ID_aluc=4'h2, ID_wreg=1, ID_valid=1 -> next edge EXE_a=32'h1234, EXE_aluc=2, EXE_wreg=1, EXE_valid=1, bubble_count=0.
- Load-use on rt: EXE holds lw with reg_w_num=5, m2reg=1, wreg=1; ID has rt=5, use_rt=1 -> load_use_stall=1; next edge EXE_valid=0, EXE_wreg=0, bubble_count=1; following edge the ID instruction loads and stall=0.
- No false stall: same as the previous scenario but reg_w_num=0, or ID_use_rt=0, or m2reg=0 -> load_use_stall=0 and no bubble.
- Hold and flush priority: assert hold for 3 cycles with changing ID inputs -> EXE_* constant and counter unchanged; assert hold=1 and flush=1 together -> bubble loaded, counter +1.
- Saturation: preload by running 65535 flushes -> bubble_count=16'hFFFF; one more flush -> stays 16'hFFFF.
- Async reset mid-stall: pulse resetn low between edges while load_use_stall=1 -> outputs 0 immediately, bubble_count=0, load_use_stall=0.
